// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter for the shared tri-state bus.
// Grants are one-hot, every ownership change passes through a one-cycle turnaround, and the owner's data is registered.
module bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             select,
  output logic             grant1,
  output logic             grant2,
  output logic             bus_valid,
  output logic [WIDTH-1:0] bus_data,
  output logic [1:0]       state
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t            cur_state, nxt_state;
  logic              last2, last2_nxt;      // 1 when requester 2 was served last
  logic              sel_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              capture;
  logic [WIDTH-1:0]  capture_data;

  // On a tie, the requester that was not served last wins.
  function automatic state_t arbitrate(input logic r1, input logic r2, input logic l2);
    state_t s;
    s = IDLE;
    if (r1 && r2)  s = l2 ? GRANT1 : GRANT2;
    else if (r1)   s = GRANT1;
    else if (r2)   s = GRANT2;
    return s;
  endfunction

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_LAST) ? v : v + HOLD_W'(1);
  endfunction

  always_comb begin
    nxt_state    = cur_state;
    hold_nxt     = hold_cnt;
    capture      = 1'b0;
    capture_data = data_in1;
    case (cur_state)
      GRANT1: begin
        capture = req1;
        if (!req1 || (hold_cnt == HOLD_LAST && req2)) nxt_state = TURN;
        else                                          hold_nxt  = sat_inc(hold_cnt);
      end
      GRANT2: begin
        capture      = req2;
        capture_data = data_in2;
        if (!req2 || (hold_cnt == HOLD_LAST && req1)) nxt_state = TURN;
        else                                          hold_nxt  = sat_inc(hold_cnt);
      end
      default: nxt_state = arbitrate(req1, req2, last2);
    endcase
  end

  // Select and last_served only move when a grant is freshly issued.
  always_comb begin
    sel_nxt   = select;
    last2_nxt = last2;
    if (cur_state == IDLE || cur_state == TURN) begin
      if (nxt_state == GRANT1) begin
        sel_nxt   = 1'b0;
        last2_nxt = 1'b0;
      end else if (nxt_state == GRANT2) begin
        sel_nxt   = 1'b1;
        last2_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      grant1    <= 1'b0;
      grant2    <= 1'b0;
      select    <= 1'b0;
      last2     <= 1'b1;
      hold_cnt  <= '0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
    end else begin
      cur_state <= nxt_state;
      grant1    <= (nxt_state == GRANT1);
      grant2    <= (nxt_state == GRANT2);
      select    <= sel_nxt;
      last2     <= last2_nxt;
      hold_cnt  <= (cur_state != nxt_state) ? '0 : hold_nxt;
      bus_valid <= capture;
      if (capture) bus_data <= capture_data;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, checked every cycle against an owner/turn reference model.
module tb_bus_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             reset, req1, req2;
  logic [WIDTH-1:0] data_in1, data_in2;
  logic             select, grant1, grant2, bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic [1:0]       state;

  bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2),
    .data_in1(data_in1), .data_in2(data_in2),
    .select(select), .grant1(grant1), .grant2(grant2),
    .bus_valid(bus_valid), .bus_data(bus_data), .state(state)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the bus, whether we are in the gap, and for how many cycles the owner has held it.
  int             m_owner;
  bit             m_turn;
  int             m_last;
  int             m_held;
  bit             m_sel;
  bit             m_valid;
  logic [WIDTH-1:0] m_data;

  task automatic model_step();
    int own_req, other_req, winner;
    if (reset) begin
      m_owner = 0; m_turn = 0; m_last = 2; m_held = 0;
      m_sel = 0; m_valid = 0; m_data = '0;
    end else if (m_owner != 0) begin
      own_req   = (m_owner == 1) ? int'(req1) : int'(req2);
      other_req = (m_owner == 1) ? int'(req2) : int'(req1);
      m_valid = own_req[0];
      if (own_req != 0) m_data = (m_owner == 1) ? data_in1 : data_in2;
      if (own_req == 0 || (m_held >= MAX_HOLD && other_req != 0)) begin
        m_owner = 0;
        m_turn  = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_valid = 0;
      m_turn  = 0;
      if (req1 && req2) winner = (m_last == 1) ? 2 : 1;
      else if (req1)    winner = 1;
      else if (req2)    winner = 2;
      else              winner = 0;
      if (winner != 0) begin
        m_owner = winner;
        m_sel   = (winner == 2);
        m_last  = winner;
        m_held  = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("grant1",    32'(grant1),    32'(m_owner == 1));
    chk("grant2",    32'(grant2),    32'(m_owner == 2));
    chk("one_hot",   32'(grant1 & grant2), 32'(0));
    chk("select",    32'(select),    32'(m_sel));
    chk("bus_valid", 32'(bus_valid), 32'(m_valid));
    chk("bus_data",  32'(bus_data),  32'(m_data));
    chk("state",     32'(state),     m_turn ? 32'd3 : 32'(m_owner));
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    reset = 1; req1 = 1; req2 = 1; data_in1 = '0; data_in2 = '0;
    m_owner = 0; m_turn = 0; m_last = 2; m_held = 0; m_sel = 0; m_valid = 0; m_data = '0;

    // Reset with both requesting, then release: requester 1 wins the first tie.
    cycle(2);
    chk("reset_state", 32'(state), 32'd0);
    reset = 0;
    cycle(1);
    chk("first_tie_g1", 32'(grant1), 32'd1);
    req1 = 0; req2 = 0;
    cycle(4);

    // Single transfer.
    req1 = 1; data_in1 = 8'hA5;
    cycle(4);
    req1 = 0;
    cycle(3);
    chk("single_data", 32'(bus_data), 32'hA5);
    chk("single_idle", 32'(state), 32'd0);

    // Continuous tie: round-robin with forced release.
    req1 = 1; req2 = 1; data_in1 = 8'h11; data_in2 = 8'h22;
    cycle(40);
    req1 = 0; req2 = 0;
    cycle(3);

    // Late contender.
    req1 = 1; data_in2 = 8'h3C;
    cycle(12);
    req2 = 1;
    cycle(3);
    chk("late_g2",  32'(grant2), 32'd1);
    chk("late_sel", 32'(select), 32'd1);
    cycle(5);
    req1 = 0; req2 = 0;
    cycle(3);

    // Handover while GRANT1 is active.
    req1 = 1; data_in1 = 8'h5A;
    cycle(3);
    req1 = 0; req2 = 1; data_in2 = 8'h3C;
    cycle(3);
    chk("handover_data", 32'(bus_data), 32'h3C);
    cycle(2);

    // Reset mid-transfer in GRANT2, then a tie goes to requester 1.
    reset = 1;
    cycle(1);
    chk("midreset_g2",  32'(grant2), 32'd0);
    chk("midreset_bd",  32'(bus_data), 32'd0);
    reset = 0; req1 = 1; req2 = 1;
    cycle(1);
    chk("post_reset_g1", 32'(grant1), 32'd1);
    req1 = 0; req2 = 0;
    cycle(2);

    // Random traffic with sticky requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      if ($urandom_range(0, 5) == 0) req2 = ~req2;
      data_in1 = WIDTH'($urandom);
      data_in2 = WIDTH'($urandom);
      reset = ($urandom_range(0, 150) == 0);
      cycle(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
